// File: rtl/seg7_count_monitor.sv
// seg7_count_monitor
//   Receive-side checker for a seven-segment counter display bus. The raw
//   segment pattern is sampled each cycle. Once it has held stable for
//   STABLE_CYCLES consecutive samples, it is decoded back to a BCD digit.
//   Accepted digits are checked against the mod-10 up-count order, and
//   9->0 wraps are counted.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   led[6:0]     segment pattern {g,f,e,d,c,b,a}
//   digit[3:0]   last accepted digit 0..9
//   digit_valid  1-cycle pulse: a new digit was accepted
//   invalid_pat  1-cycle pulse: a stable pattern that is neither a digit nor blank was accepted
//   seq_err      1-cycle pulse: the accepted digit is not the expected successor
//   wrap_cnt     saturating count of 9->0 transitions
module seg7_count_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        led,
  output logic [3:0]        digit,
  output logic              digit_valid,
  output logic              invalid_pat,
  output logic              seq_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {IDLE, TRACK} state_t;

  // Decode an active-high pattern to {is_digit, digit}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  function automatic logic [3:0] succ(input logic [3:0] d);
    succ = (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [6:0]        led_q;
  logic [6:0]        last_acc;
  logic              last_acc_vld;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  run_d;
  logic [3:0]        exp_digit;
  state_t            state, state_d;

  logic [6:0]        pat;
  logic [4:0]        dec;
  logic              accept;

  logic [3:0]        digit_d, exp_digit_d;
  logic [WRAP_W-1:0] wrap_d;
  logic              dv_d, inv_d, seq_d;

  assign pat = ACTIVE_LOW ? ~led : led;
  assign dec = decode(pat);

  // The edge that takes run from STABLE_CYCLES-1 to STABLE_CYCLES is the
  // only one that can accept, so a long stable run fires at most once.
  // Comparing against the last accepted pattern stops a glitch that
  // returns to the same pattern from being accepted twice.
  assign accept = (run == RUN_W'(STABLE_CYCLES - 1)) && (led == led_q) &&
                  (!last_acc_vld || (led != last_acc));

  always_comb begin
    run_d = run;
    if ((run == '0) || (led != led_q))
      run_d = RUN_W'(1);
    else if (run != RUN_W'(STABLE_CYCLES))
      run_d = run + RUN_W'(1);
  end

  always_comb begin
    state_d     = state;
    digit_d     = digit;
    exp_digit_d = exp_digit;
    wrap_d      = wrap_cnt;
    dv_d        = 1'b0;
    inv_d       = 1'b0;
    seq_d       = 1'b0;
    if (accept) begin
      if (dec[4]) begin
        digit_d     = dec[3:0];
        dv_d        = 1'b1;
        exp_digit_d = succ(dec[3:0]);
        state_d     = TRACK;
        if (state == TRACK) begin
          seq_d = (dec[3:0] != exp_digit);
          // digit still holds the previous accepted digit here
          if ((dec[3:0] == 4'd0) && (digit == 4'd9))
            wrap_d = sat_inc(wrap_cnt);
        end
      end else if (pat == 7'h00) begin
        state_d = IDLE;
      end else begin
        inv_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Stage 0: input sample, stability tracking, decode results registered
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q        <= '0;
      run          <= '0;
      last_acc     <= '0;
      last_acc_vld <= 1'b0;
      state        <= IDLE;
      digit        <= '0;
      exp_digit    <= '0;
      wrap_cnt     <= '0;
      digit_valid  <= 1'b0;
      invalid_pat  <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      led_q       <= led;
      run         <= run_d;
      state       <= state_d;
      digit       <= digit_d;
      exp_digit   <= exp_digit_d;
      wrap_cnt    <= wrap_d;
      digit_valid <= dv_d;
      invalid_pat <= inv_d;
      seq_err     <= seq_d;
      if (accept) begin
        last_acc     <= led;
        last_acc_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Bench for seg7_count_monitor (STABLE_CYCLES=4, ACTIVE_LOW=1).
// Stimulus pushes the expected output event of each held pattern into a
// queue; a monitor on the falling edge pops and compares whenever the DUT
// pulses one of its event outputs.
module tb_seg7_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] led;
  logic [3:0] digit;
  logic       digit_valid, invalid_pat, seq_err;
  logic [7:0] wrap_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       dv;
    logic       inv;
    logic       seq;
    logic [3:0] d;
    logic [7:0] w;
  } ev_t;

  ev_t exp_q[$];

  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] BLANK_AL = 7'h7F;

  seg7_count_monitor #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .led(led), .digit(digit),
    .digit_valid(digit_valid), .invalid_pat(invalid_pat),
    .seq_err(seq_err), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] c;
    c = CODES[d];
    return ~c;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic dv, input logic inv, input logic seq,
                      input logic [3:0] d, input logic [7:0] w);
    ev_t e;
    e = '{dv: dv, inv: inv, seq: seq, d: d, w: w};
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [6:0] v, input int n);
    led = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_dv"}, digit_valid, 0);
    chk({tag, "_inv"}, invalid_pat, 0);
    chk({tag, "_seq"}, seq_err, 0);
    chk({tag, "_wrap"}, wrap_cnt, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    ev_t a, e;
    if (!reset && (digit_valid || invalid_pat || seq_err)) begin
      a = '{dv: digit_valid, inv: invalid_pat, seq: seq_err, d: digit, w: wrap_cnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got %h expected none", a);
      end else begin
        e = exp_q.pop_front();
        if (a != e) begin
          n_bad++;
          $display("FAIL event: got dv=%0b inv=%0b seq=%0b d=%0d w=%0d expected dv=%0b inv=%0b seq=%0b d=%0d w=%0d",
                   a.dv, a.inv, a.seq, a.d, a.w, e.dv, e.inv, e.seq, e.d, e.w);
        end
      end
    end
  end

  initial begin
    // 1: reset with '0' on the bus, then check accept latency
    reset = 1'b1;
    led   = seg(0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    push(1, 0, 0, 0, 0);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk("t1_latency_dv", digit_valid, (e == 4) ? 1 : 0);
    end
    repeat (2) @(posedge clk);
    #1;

    // 2: count 1..9, 0 with a wrap at the end
    for (int d = 1; d <= 10; d++) begin
      push(1, 0, 0, 4'(d % 10), (d == 10) ? 8'd1 : 8'd0);
      hold(seg(d % 10), 6);
    end
    chk("t2_wrap", wrap_cnt, 1);

    // 3: '3' (out of order after '0'), glitch to '5', back to '3', then '4'
    push(1, 0, 1, 3, 1);
    hold(seg(3), 6);
    hold(seg(5), 2);
    hold(seg(3), 6);
    push(1, 0, 0, 4, 1);
    hold(seg(4), 6);

    // 4: '3' then '5' are both out of order, '6' resynchronises
    push(1, 0, 1, 3, 1);
    hold(seg(3), 6);
    push(1, 0, 1, 5, 1);
    hold(seg(5), 6);
    push(1, 0, 0, 6, 1);
    hold(seg(6), 6);

    // 5: '2', invalid pattern, then '7' from IDLE
    push(1, 0, 1, 2, 1);
    hold(seg(2), 6);
    push(0, 1, 0, 2, 1);
    hold(7'b0101010, 5);
    chk("t5_digit_hold", digit, 2);
    push(1, 0, 0, 7, 1);
    hold(seg(7), 6);

    // blank returns to IDLE silently; next digit has no sequence check
    hold(BLANK_AL, 6);
    chk("blank_digit_hold", digit, 7);

    // 6: count 0..7, partial '4' run, reset mid-run, then '4'
    for (int d = 0; d <= 7; d++) begin
      push(1, 0, 0, 4'(d), 1);
      hold(seg(d), 6);
    end
    hold(seg(4), 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("t6_reset");
    reset = 1'b0;
    push(1, 0, 0, 4, 0);
    hold(seg(4), 6);
    chk("t6_digit", digit, 4);

    hold(seg(4), 4);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
